// File: rtl/fwd_pkg.sv
// Shared constants, history-entry type and fwd_src width helper for the store-data
// forwarding unit.
package fwd_pkg;

    localparam int FWD_XLEN          = 32;
    localparam int FWD_RAW           = 5;
    localparam int FWD_SRC_REGF      = 0;
    localparam int FWD_SRC_WB        = 1;
    localparam int FWD_SRC_HIST_BASE = 2;

    typedef struct packed {
        logic                valid;
        logic [FWD_RAW-1:0]  rd;
        logic [FWD_XLEN-1:0] data;
    } hist_entry_t;

    function automatic int fwd_src_w(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/store_fwd_unit_if.sv
// MEM/WB side bus of the store-data forwarding unit; master drives the pipeline
// fields, slave (the unit) returns the selected store data and status.
interface store_fwd_unit_if #(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int DEPTH = 2
) ();
    localparam int SRCW = fwd_pkg::fwd_src_w(DEPTH);

    logic            mem_MemWr;
    logic [RAW-1:0]  mem_rs2;
    logic [XLEN-1:0] mem_rs2_data;
    logic            wb_valid;
    logic            wb_RegWr;
    logic [RAW-1:0]  wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] store_data;
    logic            fwd_hit;
    logic [SRCW-1:0] fwd_src;
    logic [31:0]     fwd_cnt;

    modport master (
        output mem_MemWr, mem_rs2, mem_rs2_data, wb_valid, wb_RegWr, wb_rd, wb_data,
        input  store_data, fwd_hit, fwd_src, fwd_cnt
    );

    modport slave (
        input  mem_MemWr, mem_rs2, mem_rs2_data, wb_valid, wb_RegWr, wb_rd, wb_data,
        output store_data, fwd_hit, fwd_src, fwd_cnt
    );
endinterface

// File: rtl/fwd_hist_buf.sv
// DEPTH-deep shift register of retired register writes; entry 0 is the youngest.
// Reports a per-entry rd match against the store source register.
module fwd_hist_buf #(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [RAW-1:0]             push_rd,
    input  logic [XLEN-1:0]            push_data,
    input  logic [RAW-1:0]             match_rd,
    output logic [DEPTH-1:0]           match_vec,
    output logic [DEPTH-1:0][XLEN-1:0] hist_data
);
    typedef struct packed {
        logic            valid;
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0] entries_q;
    entry_t [DEPTH-1:0] entries_d;

    // Shift in the retiring write; oldest entry falls off the end.
    always_comb begin
        entries_d = entries_q;
        if (push) begin
            entries_d[0] = '{valid: 1'b1, rd: push_rd, data: push_data};
            for (int k = 1; k < DEPTH; k++) begin
                entries_d[k] = entries_q[k-1];
            end
        end else begin
            entries_d = entries_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    always_comb begin
        match_vec = '0;
        hist_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match_vec[k] = entries_q[k].valid && (entries_q[k].rd == match_rd);
            hist_data[k] = entries_q[k].data;
        end
    end

endmodule

// File: rtl/store_fwd_unit.sv
// MEM-stage store-data forwarding: youngest of live WB result or retired-write history.
// Optional forward-event counter enabled by defining STORE_FWD_PERF_EN.
module store_fwd_unit
    import fwd_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    store_fwd_unit_if.slave      bus
);
    localparam int SRCW = fwd_src_w(DEPTH);

    logic                       push_s;
    logic                       wb_match_s;
    logic                       store_active_s;
    logic [DEPTH-1:0]           match_vec_s;
    logic [DEPTH-1:0][XLEN-1:0] hist_data_s;
    logic                       hist_hit_s;
    logic [XLEN-1:0]            hist_sel_data_s;
    logic [SRCW-1:0]            hist_sel_src_s;
    logic [XLEN-1:0]            store_data_s;
    logic                       fwd_hit_s;
    logic [SRCW-1:0]            fwd_src_s;

    assign push_s         = bus.wb_valid && bus.wb_RegWr && (bus.wb_rd != {RAW{1'b0}});
    assign wb_match_s     = push_s && (bus.wb_rd == bus.mem_rs2);
    assign store_active_s = bus.mem_MemWr && (bus.mem_rs2 != {RAW{1'b0}});

    fwd_hist_buf #(
        .XLEN  (XLEN),
        .RAW   (RAW),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_rd   (bus.wb_rd),
        .push_data (bus.wb_data),
        .match_rd  (bus.mem_rs2),
        .match_vec (match_vec_s),
        .hist_data (hist_data_s)
    );

    // Walk oldest to youngest so the youngest matching entry overrides older ones.
    always_comb begin
        hist_hit_s      = 1'b0;
        hist_sel_data_s = bus.mem_rs2_data;
        hist_sel_src_s  = SRCW'(FWD_SRC_REGF);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            hist_hit_s      = hist_hit_s | match_vec_s[k];
            hist_sel_data_s = match_vec_s[k] ? hist_data_s[k] : hist_sel_data_s;
            hist_sel_src_s  = match_vec_s[k] ? SRCW'(FWD_SRC_HIST_BASE + k) : hist_sel_src_s;
        end
    end

    always_comb begin
        store_data_s = bus.mem_rs2_data;
        fwd_hit_s    = 1'b0;
        fwd_src_s    = SRCW'(FWD_SRC_REGF);
        if (!store_active_s) begin
            store_data_s = bus.mem_rs2_data;
            fwd_hit_s    = 1'b0;
            fwd_src_s    = SRCW'(FWD_SRC_REGF);
        end else if (wb_match_s) begin
            store_data_s = bus.wb_data;
            fwd_hit_s    = 1'b1;
            fwd_src_s    = SRCW'(FWD_SRC_WB);
        end else begin
            store_data_s = hist_sel_data_s;
            fwd_hit_s    = hist_hit_s;
            fwd_src_s    = hist_sel_src_s;
        end
    end

    assign bus.store_data = store_data_s;
    assign bus.fwd_hit    = fwd_hit_s;
    assign bus.fwd_src    = fwd_src_s;

`ifdef STORE_FWD_PERF_EN
    logic [31:0] fwd_cnt_q;
    logic [31:0] fwd_cnt_d;

    // Saturating count of cycles that forwarded store data.
    always_comb begin
        fwd_cnt_d = fwd_cnt_q;
        if (fwd_hit_s && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end else begin
            fwd_cnt_d = fwd_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_cnt_q <= 32'd0;
        end else begin
            fwd_cnt_q <= fwd_cnt_d;
        end
    end

    assign bus.fwd_cnt = fwd_cnt_q;
`else
    assign bus.fwd_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_store_fwd_unit.sv
// Bench for store_fwd_unit: directed vector table, a hold sequence, then random traffic
// against a queue-based model of the forwarding rules.
module tb_store_fwd_unit;

    localparam int XLEN  = 32;
    localparam int RAW   = 5;
    localparam int DEPTH = 2;

    typedef struct {
        logic            rst;
        logic            memwr;
        logic [RAW-1:0]  rs2;
        logic [XLEN-1:0] rs2d;
        logic            wbv;
        logic            wbw;
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] wbd;
        logic [XLEN-1:0] e_data;
        logic            e_hit;
        logic [1:0]      e_src;
    } vec_t;

    typedef struct {
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ent_t        hq[$];
    logic [31:0] m_cnt = 32'd0;
    vec_t        tbl[21];

    store_fwd_unit_if #(.XLEN(XLEN), .RAW(RAW), .DEPTH(DEPTH)) bus ();

    store_fwd_unit #(.XLEN(XLEN), .RAW(RAW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic mw, input logic [4:0] s2,
                                input logic [31:0] s2d, input logic v, input logic w,
                                input logic [4:0] d, input logic [31:0] wd,
                                input logic [31:0] ed, input logic eh, input logic [1:0] es);
        vec_t t;
        t.rst = r; t.memwr = mw; t.rs2 = s2; t.rs2d = s2d; t.wbv = v; t.wbw = w;
        t.rd = d; t.wbd = wd; t.e_data = ed; t.e_hit = eh; t.e_src = es;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference rules: non-store -> regfile; live WB beats history; youngest history entry wins.
    task automatic mdl_eval(input vec_t v, output logic [31:0] d, output logic h,
                            output logic [1:0] s);
        d = v.rs2d; h = 1'b0; s = 2'd0;
        if (v.memwr && v.rs2 != 5'd0) begin
            if (v.wbv && v.wbw && v.rd != 5'd0 && v.rd == v.rs2) begin
                d = v.wbd; h = 1'b1; s = 2'd1;
            end else begin
                for (int i = 0; i < hq.size(); i++) begin
                    if (!h && hq[i].rd == v.rs2) begin
                        d = hq[i].data; h = 1'b1; s = 2'(2 + i);
                    end
                end
            end
        end
    endtask

    task automatic mdl_update(input vec_t v, input logic hit);
        ent_t e;
        if (v.rst) begin
            hq.delete();
            m_cnt = 32'd0;
        end else begin
            if (v.wbv && v.wbw && v.rd != 5'd0) begin
                e.rd = v.rd; e.data = v.wbd;
                hq.push_front(e);
                if (hq.size() > DEPTH) void'(hq.pop_back());
            end
            if (hit && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic apply(input vec_t v, input bit use_tbl, input string tag);
        logic [31:0] md;
        logic        mh;
        logic [1:0]  ms;
        logic [31:0] ecnt;
        rst              = v.rst;
        bus.mem_MemWr    = v.memwr;
        bus.mem_rs2      = v.rs2;
        bus.mem_rs2_data = v.rs2d;
        bus.wb_valid     = v.wbv;
        bus.wb_RegWr     = v.wbw;
        bus.wb_rd        = v.rd;
        bus.wb_data      = v.wbd;
        #1;
        mdl_eval(v, md, mh, ms);
        if (use_tbl) begin
            md = v.e_data; mh = v.e_hit; ms = v.e_src;
        end
`ifdef STORE_FWD_PERF_EN
        ecnt = m_cnt;
`else
        ecnt = 32'd0;
`endif
        chk({tag, ".store_data"}, 64'(bus.store_data), 64'(md));
        chk({tag, ".fwd_hit"},    64'(bus.fwd_hit),    64'(mh));
        chk({tag, ".fwd_src"},    64'(bus.fwd_src),    64'(ms));
        chk({tag, ".fwd_cnt"},    64'(bus.fwd_cnt),    64'(ecnt));
        mdl_update(v, mh);
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        // r  mw rs2    rs2d          wbv  wbw  rd     wbd            e_data        hit   src
        tbl[0]  = mk(1'b1, 1'b0, 5'd0, 32'h55, 1'b0, 1'b0, 5'd0, 32'h0,  32'h55, 1'b0, 2'd0);
        tbl[1]  = mk(1'b0, 1'b1, 5'd5, 32'h99, 1'b1, 1'b1, 5'd5, 32'h11, 32'h11, 1'b1, 2'd1);
        tbl[2]  = mk(1'b0, 1'b0, 5'd5, 32'h22, 1'b1, 1'b1, 5'd5, 32'hAA, 32'h22, 1'b0, 2'd0);
        tbl[3]  = mk(1'b0, 1'b0, 5'd0, 32'h23, 1'b0, 1'b0, 5'd0, 32'h0,  32'h23, 1'b0, 2'd0);
        tbl[4]  = mk(1'b0, 1'b1, 5'd5, 32'h44, 1'b0, 1'b0, 5'd0, 32'h0,  32'hAA, 1'b1, 2'd2);
        tbl[5]  = mk(1'b0, 1'b0, 5'd0, 32'h05, 1'b1, 1'b1, 5'd5, 32'h1,  32'h05, 1'b0, 2'd0);
        tbl[6]  = mk(1'b0, 1'b0, 5'd0, 32'h06, 1'b1, 1'b1, 5'd5, 32'h2,  32'h06, 1'b0, 2'd0);
        tbl[7]  = mk(1'b0, 1'b1, 5'd5, 32'h07, 1'b0, 1'b0, 5'd0, 32'h0,  32'h02, 1'b1, 2'd2);
        tbl[8]  = mk(1'b0, 1'b1, 5'd0, 32'h08, 1'b1, 1'b1, 5'd0, 32'hFF, 32'h08, 1'b0, 2'd0);
        tbl[9]  = mk(1'b0, 1'b1, 5'd0, 32'h09, 1'b0, 1'b0, 5'd0, 32'h0,  32'h09, 1'b0, 2'd0);
        tbl[10] = mk(1'b0, 1'b0, 5'd0, 32'h0A, 1'b1, 1'b1, 5'd7, 32'h77, 32'h0A, 1'b0, 2'd0);
        tbl[11] = mk(1'b0, 1'b1, 5'd7, 32'h0B, 1'b0, 1'b0, 5'd0, 32'h0,  32'h77, 1'b1, 2'd2);
        tbl[12] = mk(1'b0, 1'b0, 5'd0, 32'h0C, 1'b1, 1'b1, 5'd1, 32'h10, 32'h0C, 1'b0, 2'd0);
        tbl[13] = mk(1'b0, 1'b1, 5'd7, 32'h0D, 1'b0, 1'b0, 5'd0, 32'h0,  32'h77, 1'b1, 2'd3);
        tbl[14] = mk(1'b0, 1'b0, 5'd0, 32'h0E, 1'b1, 1'b1, 5'd2, 32'h20, 32'h0E, 1'b0, 2'd0);
        tbl[15] = mk(1'b0, 1'b1, 5'd7, 32'h0F, 1'b0, 1'b0, 5'd0, 32'h0,  32'h0F, 1'b0, 2'd0);
        tbl[16] = mk(1'b0, 1'b1, 5'd2, 32'h1F, 1'b1, 1'b0, 5'd2, 32'h99, 32'h20, 1'b1, 2'd2);
        tbl[17] = mk(1'b1, 1'b0, 5'd2, 32'h2F, 1'b0, 1'b0, 5'd0, 32'h0,  32'h2F, 1'b0, 2'd0);
        tbl[18] = mk(1'b0, 1'b1, 5'd2, 32'h3F, 1'b0, 1'b0, 5'd0, 32'h0,  32'h3F, 1'b0, 2'd0);
        tbl[19] = mk(1'b0, 1'b1, 5'd2, 32'h4F, 1'b1, 1'b1, 5'd2, 32'h55, 32'h55, 1'b1, 2'd1);
        tbl[20] = mk(1'b0, 1'b1, 5'd2, 32'h5F, 1'b1, 1'b1, 5'd2, 32'h66, 32'h66, 1'b1, 2'd1);

        bus.mem_MemWr = 1'b0; bus.mem_rs2 = 5'd0; bus.mem_rs2_data = 32'd0;
        bus.wb_valid = 1'b0; bus.wb_RegWr = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 21; i++) begin
            apply(tbl[i], 1'b1, $sformatf("vec%0d", i));
        end

        // MEM hold: x3 retired, then three stalled cycles with no retire; select must not move.
        apply(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd3, 32'h3333, 32'h0, 1'b0, 2'd0),
              1'b0, "hold_push");
        for (int i = 0; i < 3; i++) begin
            v = mk(1'b0, 1'b1, 5'd3, 32'hDEAD, 1'b0, 1'b1, 5'd3, 32'hBEEF, 32'h0, 1'b0, 2'd0);
            rst = 1'b0;
            bus.mem_MemWr = 1'b1; bus.mem_rs2 = 5'd3; bus.mem_rs2_data = 32'hDEAD;
            bus.wb_valid = 1'b0; bus.wb_RegWr = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hBEEF;
            #1;
            chk($sformatf("hold%0d.store_data", i), 64'(bus.store_data), 64'h3333);
            chk($sformatf("hold%0d.fwd_src", i),    64'(bus.fwd_src),    64'd2);
            mdl_update(v, 1'b1);
            @(negedge clk);
        end

        for (int i = 0; i < 400; i++) begin
            v.rst   = ($urandom_range(0, 39) == 0);
            v.memwr = $urandom_range(0, 1) == 1;
            v.rs2   = 5'($urandom_range(0, 7));
            v.rs2d  = $urandom;
            v.wbv   = $urandom_range(0, 9) < 6;
            v.wbw   = $urandom_range(0, 9) < 7;
            v.rd    = 5'($urandom_range(0, 7));
            v.wbd   = $urandom;
            v.e_data = 32'd0; v.e_hit = 1'b0; v.e_src = 2'd0;
            apply(v, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
